// File: rtl/stop_it_pkg.sv
// ============================================================================
// Module   : stop_it_pkg
// Brief    : Shared state encoding, default parameters and LFSR tap table for
//            the stop_it_rounds reaction game.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stop_it_pkg;

    localparam int c_DEF_CNT_W       = 5;
    localparam int c_DEF_START_TICKS = 8;
    localparam int c_DEF_FLASH_TICKS = 16;
    localparam int c_DEF_NUM_LEDS    = 16;

    typedef enum logic [2:0] {
        WAITING_TO_START = 3'd0,
        STARTING         = 3'd1,
        DECREMENTING     = 3'd2,
        CORRECT          = 3'd3,
        WRONG            = 3'd4,
        WON              = 3'd5
    } state_t;

    // Fibonacci tap masks (shift-left, feedback into bit 0), maximal length.
    function automatic logic [7:0] lfsr_taps(input int width);
        logic [7:0] taps;
        case (width)
            2:       taps = 8'b0000_0011;
            3:       taps = 8'b0000_0110;
            4:       taps = 8'b0000_1100;
            5:       taps = 8'b0001_0100;
            6:       taps = 8'b0011_0000;
            7:       taps = 8'b0110_0000;
            default: taps = 8'b1011_1000;
        endcase
        return taps;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_n.sv
// ============================================================================
// Module   : lfsr_n
// Brief    : Free-running maximal-length LFSR, seeded to 1, never reaches zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_n
    import stop_it_pkg::*;
#(
    parameter int WIDTH = c_DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [WIDTH-1:0] value_o
);

    localparam logic [WIDTH-1:0] c_TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & c_TAPS)};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= WIDTH'(1);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/stop_it_rounds.sv
// ============================================================================
// Module   : stop_it_rounds
// Brief    : "Stop it" reaction game: count down, press stop on the target,
//            score shifts into an LED bar. Macro STOP_IT_TOLERANCE_EN widens
//            a hit to a modular distance of one.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stop_it_rounds
    import stop_it_pkg::*;
#(
    parameter int CNT_W       = c_DEF_CNT_W,
    parameter int START_TICKS = c_DEF_START_TICKS,
    parameter int FLASH_TICKS = c_DEF_FLASH_TICKS,
    parameter int NUM_LEDS    = c_DEF_NUM_LEDS
) (
    input  logic                clk_4_i,
    input  logic                rst_i,
    input  logic                go_i,
    input  logic                stop_i,
    input  logic                load_i,
    output logic [NUM_LEDS-1:0] leds_o,
    output logic                digit0_en_o,
    output logic                digit1_en_o,
    output logic                digit2_en_o,
    output logic                digit3_en_o,
    output logic [3:0]          digit0_o,
    output logic [3:0]          digit1_o,
    output logic [3:0]          digit2_o,
    output logic [3:0]          digit3_o,
    output state_t              state_o
);

    localparam int c_TICK_MAX = (START_TICKS > FLASH_TICKS) ? START_TICKS : FLASH_TICKS;
    localparam int c_TICK_W   = (c_TICK_MAX > 1) ? $clog2(c_TICK_MAX) : 1;

    localparam logic [c_TICK_W-1:0] c_START_LAST = c_TICK_W'(START_TICKS - 1);
    localparam logic [c_TICK_W-1:0] c_FLASH_LAST = c_TICK_W'(FLASH_TICKS - 1);

    state_t              state_q,  state_d;
    logic [CNT_W-1:0]    count_q,  count_d;
    logic [CNT_W-1:0]    target_q, target_d;
    logic [c_TICK_W-1:0] tick_q,   tick_d;
    logic [NUM_LEDS-1:0] leds_q,   leds_d;

    logic [CNT_W-1:0]    w_lfsr;
    logic                w_hit;
    logic [CNT_W-1:0]    w_diff;
    logic [NUM_LEDS-1:0] w_leds_one;
    logic [NUM_LEDS-1:0] w_leds_zero;
    logic [CNT_W-1:0]    w_show;

    lfsr_n #(
        .WIDTH (CNT_W)
    ) u_lfsr (
        .clk_i   (clk_4_i),
        .rst_i   (rst_i),
        .value_o (w_lfsr)
    );

    assign w_diff = count_q - target_q;

`ifdef STOP_IT_TOLERANCE_EN
    assign w_hit = (w_diff == '0) || (w_diff == CNT_W'(1)) || (w_diff == '1);
`else
    assign w_hit = (w_diff == '0);
`endif

    assign w_leds_one  = {leds_q[NUM_LEDS-2:0], 1'b1};
    assign w_leds_zero = {leds_q[NUM_LEDS-2:0], 1'b0};

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        target_d = target_q;
        tick_d   = tick_q;
        leds_d   = leds_q;

        if (load_i && (state_q != WON)) begin
            leds_d  = '1;
            state_d = WON;
        end else begin
            case (state_q)
                WAITING_TO_START: begin
                    if (go_i) begin
                        target_d = w_lfsr;
                        count_d  = '1;
                        tick_d   = '0;
                        state_d  = STARTING;
                    end
                end
                STARTING: begin
                    if (tick_q == c_START_LAST) begin
                        tick_d  = '0;
                        state_d = DECREMENTING;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DECREMENTING: begin
                    if (stop_i) begin
                        tick_d  = '0;
                        state_d = w_hit ? CORRECT : WRONG;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
                CORRECT: begin
                    if (tick_q == c_FLASH_LAST) begin
                        tick_d  = '0;
                        leds_d  = w_leds_one;
                        state_d = (&w_leds_one) ? WON : WAITING_TO_START;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                WRONG: begin
                    if (tick_q == c_FLASH_LAST) begin
                        tick_d  = '0;
                        leds_d  = w_leds_zero;
                        state_d = WAITING_TO_START;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                WON: begin
                    if (go_i) begin
                        leds_d  = '0;
                        state_d = WAITING_TO_START;
                    end else begin
                        leds_d = ~leds_q;
                    end
                end
                default: begin
                    state_d = WAITING_TO_START;
                end
            endcase
        end
    end

    always_ff @(posedge clk_4_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= WAITING_TO_START;
            count_q  <= '1;
            target_q <= '0;
            tick_q   <= '0;
            leds_q   <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            target_q <= target_d;
            tick_q   <= tick_d;
            leds_q   <= leds_d;
        end
    end

    // WON shows a solid all-ones value regardless of where the count stopped.
    assign w_show   = (state_q == WON) ? '1 : count_q;
    assign digit0_o = 4'(w_show);
    assign digit1_o = 4'(w_show >> 4);
    assign digit2_o = 4'(target_q);
    assign digit3_o = 4'(target_q >> 4);

    always_comb begin
        digit0_en_o = 1'b1;
        digit1_en_o = 1'b1;
        digit2_en_o = 1'b0;
        digit3_en_o = 1'b0;
        case (state_q)
            STARTING, DECREMENTING: begin
                digit2_en_o = 1'b1;
                digit3_en_o = 1'b1;
            end
            CORRECT: begin
                digit0_en_o = ~tick_q[0];
                digit1_en_o = ~tick_q[0];
                digit2_en_o = ~tick_q[0];
                digit3_en_o = ~tick_q[0];
            end
            WRONG: begin
                digit0_en_o = tick_q[0];
                digit1_en_o = tick_q[0];
                digit2_en_o = ~tick_q[0];
                digit3_en_o = ~tick_q[0];
            end
            default: begin
                digit0_en_o = 1'b1;
            end
        endcase
    end

    assign leds_o  = leds_q;
    assign state_o = state_q;

endmodule

`default_nettype wire
